// File: rtl/regfile_scan.sv
// Debug-side sequencer for the 32x32 CPU register file: streams a register
// range out to the host (dump) or writes host words into a range (load).
module regfile_scan #(
  parameter int READ_LAT = 1
) (
  input  logic        CK,
  input  logic        CLR,
  input  logic        Start,
  input  logic        Load,
  input  logic [4:0]  FirstReg,
  input  logic [4:0]  LastReg,
  output logic        Busy,
  output logic        Done,
  output logic [4:0]  RegAddr,
  input  logic [31:0] RegData,
  output logic        RegWrite,
  output logic [4:0]  WriteRegster,
  output logic [31:0] WriteData,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady
);

  localparam int CW = $clog2(READ_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_OUT,
    WR,
    FLUSH,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [4:0]    cur_reg, cur_next;
  logic [4:0]    last_reg, last_next;
  logic [CW-1:0] lat_reg, lat_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [4:0]    addr_reg, addr_next;
  logic          wr_reg, wr_next;
  logic [4:0]    wa_reg, wa_next;
  logic [31:0]   wd_reg, wd_next;
  logic [31:0]   out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;
  logic          in_ready_reg, in_ready_next;

  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    last_next      = last_reg;
    lat_next       = lat_reg;
    addr_next      = addr_reg;
    wr_next        = 1'b0;
    wa_next        = wa_reg;
    wd_next        = wd_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (Start || Load) begin
          cur_next  = FirstReg;
          last_next = LastReg;
          lat_next  = '0;
          if (Start) begin
            addr_next = FirstReg;
          end
          if (FirstReg > LastReg) begin
            state_next = DONE;
          end else if (Start) begin
            state_next = RD_WAIT;
          end else begin
            state_next = WR;
          end
        end
      end

      // One cycle for the address to reach the file plus READ_LAT of latency.
      RD_WAIT: begin
        if (lat_reg == CW'(READ_LAT)) begin
          out_data_next  = RegData;
          out_valid_next = 1'b1;
          state_next     = RD_OUT;
        end else begin
          lat_next = lat_reg + CW'(1);
        end
      end

      RD_OUT: begin
        if (out_valid_reg && OutReady) begin
          out_valid_next = 1'b0;
          if (cur_reg == last_reg) begin
            state_next = DONE;
          end else begin
            cur_next   = cur_reg + 5'd1;
            addr_next  = cur_reg + 5'd1;
            lat_next   = '0;
            state_next = RD_WAIT;
          end
        end
      end

      // r0 is hardwired in the CPU, so its word is accepted but never written.
      WR: begin
        if (InValid && in_ready_reg) begin
          wr_next = (cur_reg != 5'd0);
          wa_next = cur_reg;
          wd_next = InData;
          if (cur_reg == last_reg) begin
            state_next = FLUSH;
          end else begin
            cur_next = cur_reg + 5'd1;
          end
        end
      end

      FLUSH: state_next = DONE;

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    in_ready_next = (state_next == WR);
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_reg     <= IDLE;
      cur_reg       <= 5'd0;
      last_reg      <= 5'd0;
      lat_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      addr_reg      <= 5'd0;
      wr_reg        <= 1'b0;
      wa_reg        <= 5'd0;
      wd_reg        <= 32'd0;
      out_data_reg  <= 32'd0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      last_reg      <= last_next;
      lat_reg       <= lat_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      addr_reg      <= addr_next;
      wr_reg        <= wr_next;
      wa_reg        <= wa_next;
      wd_reg        <= wd_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign Busy         = busy_reg;
  assign Done         = done_reg;
  assign RegAddr      = addr_reg;
  assign RegWrite     = wr_reg;
  assign WriteRegster = wa_reg;
  assign WriteData    = wd_reg;
  assign OutData      = out_data_reg;
  assign OutValid     = out_valid_reg;
  assign InReady      = in_ready_reg;

endmodule
